// File: rtl/simple_risc_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the SimpleRISC decode stage.
// The slave modport is the stage itself; master is whoever drives fetch and consumes the bundle.
interface simple_risc_decode_stage_if #(
  parameter int unsigned INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [14:0]       out_alu_signals;
  logic              out_is_ret;
  logic              out_is_st;
  logic              out_is_wb;
  logic              out_is_beq;
  logic              out_is_bgt;
  logic              out_is_ubranch;
  logic              out_is_ld;
  logic              out_is_call;
  logic              out_is_immediate;
  logic              out_illegal;
  logic              busy;

  modport master (
    output in_valid, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_alu_signals, out_is_ret, out_is_st, out_is_wb,
           out_is_beq, out_is_bgt, out_is_ubranch, out_is_ld, out_is_call, out_is_immediate,
           out_illegal, busy
  );

  modport slave (
    input  in_valid, in_inst, flush, out_ready,
    output in_ready, out_valid, out_inst, out_alu_signals, out_is_ret, out_is_st, out_is_wb,
           out_is_beq, out_is_bgt, out_is_ubranch, out_is_ld, out_is_call, out_is_immediate,
           out_illegal, busy
  );
endinterface

// File: rtl/simple_risc_decode_stage.sv
// SimpleRISC decode stage: decodes the fetched word into the control bundle, holds it in a
// valid/ready pipeline register and stalls fetch while a mul/div/mod occupies execute.
module simple_risc_decode_stage #(
  parameter int unsigned INST_W  = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  simple_risc_decode_stage_if.slave   bus
);

  localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat) + 1;

  typedef struct packed {
    logic [14:0] alu;
    logic        isRet;
    logic        isSt;
    logic        isWb;
    logic        isBeq;
    logic        isBgt;
    logic        isUbranch;
    logic        isLd;
    logic        isCall;
    logic        isImmediate;
    logic        illegal;
  } ctrlT;

  logic [4:0]        opcode;
  ctrlT              ctrlDec;
  ctrlT              ctrlQ, ctrlD;
  logic [INST_W-1:0] instQ, instD;
  logic              outValidQ, outValidD;
  logic [CntW-1:0]   cntQ, cntD;
  logic              busy;
  logic              inReady;
  logic              accept;
  logic              xfer;
  logic              heldMul;
  logic              heldDiv;

  assign opcode = bus.in_inst[INST_W-1 -: 5];

  always_comb begin
    ctrlDec             = '0;
    ctrlDec.isImmediate = bus.in_inst[INST_W-6];
    if (opcode <= 5'd12) begin
      // Arithmetic/logic opcodes map straight onto the low alu bits; only cmp skips writeback.
      ctrlDec.alu  = 15'd1 << opcode;
      ctrlDec.isWb = (opcode != 5'd5);
    end else begin
      case (opcode)
        5'd13: ;
        5'd14: begin
          ctrlDec.alu[13] = 1'b1;
          ctrlDec.isLd    = 1'b1;
          ctrlDec.isWb    = 1'b1;
        end
        5'd15: begin
          ctrlDec.alu[14] = 1'b1;
          ctrlDec.isSt    = 1'b1;
        end
        5'd16: ctrlDec.isBeq = 1'b1;
        5'd17: ctrlDec.isBgt = 1'b1;
        5'd18: ctrlDec.isUbranch = 1'b1;
        5'd19: begin
          ctrlDec.isUbranch = 1'b1;
          ctrlDec.isCall    = 1'b1;
          ctrlDec.isWb      = 1'b1;
        end
        5'd20: begin
          ctrlDec.isUbranch = 1'b1;
          ctrlDec.isRet     = 1'b1;
        end
        default: ctrlDec.illegal = 1'b1;
      endcase
    end
  end

  assign busy    = (cntQ != '0);
  assign inReady = !rst && !bus.flush && !busy && (!outValidQ || bus.out_ready);
  assign accept  = bus.in_valid && inReady;
  assign xfer    = outValidQ && bus.out_ready;
  assign heldMul = ctrlQ.alu[2];
  assign heldDiv = ctrlQ.alu[3] || ctrlQ.alu[4];

  always_comb begin
    ctrlD     = ctrlQ;
    instD     = instQ;
    outValidD = outValidQ;
    cntD      = cntQ;
    if (accept) begin
      ctrlD     = ctrlDec;
      instD     = bus.in_inst;
      outValidD = 1'b1;
    end else if (xfer || bus.flush) begin
      outValidD = 1'b0;
    end
    // Flush never clears the counter: execute is still busy with the op already handed over.
    if (xfer && heldMul) begin
      cntD = CntW'(MUL_LAT - 1);
    end else if (xfer && heldDiv) begin
      cntD = CntW'(DIV_LAT - 1);
    end else if (busy) begin
      cntD = cntQ - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrlQ     <= '0;
      instQ     <= '0;
      outValidQ <= 1'b0;
      cntQ      <= '0;
    end else begin
      ctrlQ     <= ctrlD;
      instQ     <= instD;
      outValidQ <= outValidD;
      cntQ      <= cntD;
    end
  end

  assign bus.in_ready         = inReady;
  assign bus.busy             = busy;
  assign bus.out_valid        = outValidQ;
  assign bus.out_inst         = instQ;
  assign bus.out_alu_signals  = ctrlQ.alu;
  assign bus.out_is_ret       = ctrlQ.isRet;
  assign bus.out_is_st        = ctrlQ.isSt;
  assign bus.out_is_wb        = ctrlQ.isWb;
  assign bus.out_is_beq       = ctrlQ.isBeq;
  assign bus.out_is_bgt       = ctrlQ.isBgt;
  assign bus.out_is_ubranch   = ctrlQ.isUbranch;
  assign bus.out_is_ld        = ctrlQ.isLd;
  assign bus.out_is_call      = ctrlQ.isCall;
  assign bus.out_is_immediate = ctrlQ.isImmediate;
  assign bus.out_illegal      = ctrlQ.illegal;

endmodule

// File: tb/tb_simple_risc_decode_stage.sv
// Bench for simple_risc_decode_stage: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of the stage.
module tb_simple_risc_decode_stage;

  localparam int unsigned MulLat = 2;
  localparam int unsigned DivLat = 8;

  typedef struct packed {
    logic [14:0] alu;
    logic [9:0]  flags;  // {illegal, imm, call, ld, ubranch, bgt, beq, wb, st, ret}
  } expT;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference state: what downstream should currently see.
  bit          mKnown;
  bit          mValid;
  bit          mPostRst;
  logic [31:0] mInst;
  expT         mExp;
  int          mCnt;
  bit          lastAccept;

  simple_risc_decode_stage_if #(.INST_W(32)) bus ();

  simple_risc_decode_stage #(
    .INST_W (32),
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic expT refDecode(logic [31:0] inst);
    expT e;
    int  op;
    bit  ill, wb;
    op      = int'(inst[31:27]);
    e       = '0;
    if (op <= 12) e.alu[op] = 1'b1;
    if (op == 14) e.alu[13] = 1'b1;
    if (op == 15) e.alu[14] = 1'b1;
    ill = (op > 20);
    wb  = !ill && !(op inside {5, 13, 15, 16, 17, 18, 20});
    e.flags = {ill, inst[26], op == 19, op == 14, op inside {18, 19, 20},
               op == 17, op == 16, wb, op == 15, op == 20};
    return e;
  endfunction

  function automatic logic [31:0] mk(int op, bit imm);
    logic [31:0] r;
    r = $urandom();
    return {op[4:0], imm, r[25:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit rdy, acc, xfer;
    int op;
    @(negedge clk);
    rdy = !rst && !bus.flush && (mCnt == 0) && (!mValid || bus.out_ready);
    chk("in_ready", bus.in_ready, rdy);
    if (mKnown) begin
      chk("out_valid", bus.out_valid, mValid);
      chk("busy", bus.busy, mCnt != 0);
      if (mValid || mPostRst) begin
        chk("out_inst", bus.out_inst, mInst);
        chk("out_alu", bus.out_alu_signals, mExp.alu);
        chk("out_flags", {bus.out_illegal, bus.out_is_immediate, bus.out_is_call, bus.out_is_ld,
                          bus.out_is_ubranch, bus.out_is_bgt, bus.out_is_beq, bus.out_is_wb,
                          bus.out_is_st, bus.out_is_ret}, mExp.flags);
      end
    end
    acc        = bus.in_valid && rdy;
    xfer       = mValid && bus.out_ready;
    op         = int'(mInst[31:27]);
    lastAccept = acc;
    @(posedge clk);
    #1;
    if (rst) begin
      mKnown   = 1'b1;
      mValid   = 1'b0;
      mPostRst = 1'b1;
      mInst    = '0;
      mExp     = '0;
      mCnt     = 0;
    end else begin
      if (xfer && op == 2)                      mCnt = MulLat - 1;
      else if (xfer && (op == 3 || op == 4))    mCnt = DivLat - 1;
      else if (mCnt > 0)                        mCnt--;
      if (acc) begin
        mValid   = 1'b1;
        mPostRst = 1'b0;
        mInst    = bus.in_inst;
        mExp     = refDecode(bus.in_inst);
      end else if (xfer || bus.flush) begin
        mValid = 1'b0;
      end
    end
  endtask

  task automatic send(logic [31:0] inst);
    bus.in_valid = 1'b1;
    bus.in_inst  = inst;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (lastAccept) break;
    end
    checks++;
    assert (lastAccept)
    else begin
      failures++;
      $error("FAIL send_timeout observed=no_accept expected=accept inst=%0h", inst);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    mKnown        = 1'b0;
    mValid        = 1'b0;
    mPostRst      = 1'b0;
    mInst         = '0;
    mExp          = '0;
    mCnt          = 0;
    lastAccept    = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Decode sweep with spot checks on a few known encodings.
    for (int op = 0; op < 32; op++) begin
      for (int i = 0; i < 2; i++) begin
        send(mk(op, i[0]));
        if (op == 5 && i == 0) begin
          chk("op5_alu", bus.out_alu_signals, 15'h0020);
          chk("op5_wb", bus.out_is_wb, 1'b0);
        end
        if (op == 19 && i == 1) begin
          chk("op19_call", {bus.out_is_ubranch, bus.out_is_call, bus.out_is_wb}, 3'b111);
          chk("op19_imm", bus.out_is_immediate, 1'b1);
        end
        if (op == 22 && i == 0) begin
          chk("op22_ill", {bus.out_illegal, bus.out_alu_signals, bus.out_is_wb}, {1'b1, 16'h0});
        end
      end
    end
    bus.in_valid = 1'b0;
    repeat (10) cycle();

    // Streaming adds.
    for (int k = 0; k < 8; k++) send(mk(0, k[0]));
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    // Back-pressure on a held sub, then release with the next word waiting.
    send(mk(1, 1'b0));
    bus.out_ready = 1'b0;
    bus.in_inst   = mk(0, 1'b1);
    repeat (3) cycle();
    bus.out_ready = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    // Div then mul bubbles with fetch continuously offering adds.
    send(mk(3, 1'b0));
    bus.in_inst = mk(0, 1'b0);
    repeat (12) cycle();
    send(mk(2, 1'b1));
    bus.in_inst = mk(0, 1'b0);
    repeat (5) cycle();
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    // Flush while stalled, then flush during a mod bubble.
    bus.out_ready = 1'b0;
    send(mk(0, 1'b0));
    bus.flush = 1'b1;
    cycle();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    send(mk(4, 1'b0));
    bus.in_valid = 1'b0;
    cycle();
    bus.flush = 1'b1;
    repeat (3) cycle();
    bus.flush = 1'b0;
    repeat (6) cycle();

    // Reset in the middle of a div bubble with a bundle held.
    send(mk(3, 1'b1));
    bus.in_inst = mk(0, 1'b1);
    cycle();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) cycle();

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      bus.in_inst   = $urandom();
      cycle();
    end
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
